// File: rtl/spi_sram_word_if.sv
// spi_sram_word_if: CPU word read/write requests executed as SPI mode-0 frames to a 23LC-style serial SRAM.
// Optional SPI_SRAM_INIT_EN: after reset, send WRMR (0x01 0x40) before accepting requests.
module spi_sram_word_if #(
   parameter int ADDR_BITS  = 16,
   parameter int DATA_BYTES = 2,
   parameter int CLK_DIV    = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [ADDR_BITS-1:0]    addr_in,
   input  logic [8*DATA_BYTES-1:0] data_in,
   input  logic                    start_read,
   input  logic                    start_write,
   output logic [8*DATA_BYTES-1:0] data_out,
   output logic                    busy,
   output logic                    spi_select,
   output logic                    spi_clk_out,
   output logic                    spi_mosi,
   input  logic                    spi_miso
);
   localparam int DW    = 8 * DATA_BYTES;
   localparam int NBITS = 8 + ADDR_BITS + DW;
   localparam int BW    = $clog2(NBITS);
   localparam int CW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t            state, state_n;
   logic              init_pend, go, tick, is_rd;
   logic [NBITS-1:0]  frame, load;
   logic [DW-1:0]     rx;
   logic [CW-1:0]     div_cnt;
   logic [BW-1:0]     bit_cnt, last_bit;

`ifdef SPI_SRAM_INIT_EN
   always_ff @(posedge clk or posedge rst)
      if (rst) init_pend <= 1'b1;
      else if (state == IDLE) init_pend <= 1'b0;
`else
   assign init_pend = 1'b0;
`endif

   assign go   = init_pend | start_read | start_write;
   assign tick = div_cnt == CW'(CLK_DIV - 1);
   // init frame is left-aligned so it shifts out through the same MSB as a normal frame
   assign load = init_pend ? {16'h0140, {(NBITS-16){1'b0}}}
                           : {start_write ? 8'h02 : 8'h03, addr_in, start_write ? data_in : {DW{1'b0}}};

   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= state_n;

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    state_n = go ? SHIFT : IDLE;
         SHIFT:   state_n = (tick && spi_clk_out && bit_cnt == last_bit) ? DONE : SHIFT;
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         spi_select  <= 1'b1;
         spi_clk_out <= 1'b0;
         spi_mosi    <= 1'b0;
         busy        <= 1'b0;
         data_out    <= '0;
         frame       <= '0;
         rx          <= '0;
         div_cnt     <= '0;
         bit_cnt     <= '0;
         last_bit    <= '0;
         is_rd       <= 1'b0;
      end else begin
         case (state)
            IDLE: if (go) begin
               busy        <= 1'b1;
               spi_select  <= 1'b0;
               spi_clk_out <= 1'b0;
               frame       <= load;
               spi_mosi    <= load[NBITS-1];
               div_cnt     <= '0;
               bit_cnt     <= '0;
               last_bit    <= init_pend ? BW'(15) : BW'(NBITS - 1);
               is_rd       <= ~init_pend & ~start_write & start_read;
            end
            SHIFT: if (!tick) div_cnt <= div_cnt + CW'(1);
            else begin
               div_cnt <= '0;
               if (!spi_clk_out) begin
                  spi_clk_out <= 1'b1;
                  rx          <= {rx[DW-2:0], spi_miso};
               end else begin
                  spi_clk_out <= 1'b0;
                  if (bit_cnt != last_bit) begin
                     frame    <= {frame[NBITS-2:0], 1'b0};
                     spi_mosi <= frame[NBITS-2];
                     bit_cnt  <= bit_cnt + BW'(1);
                  end
               end
            end
            DONE: begin
               spi_select <= 1'b1;
               spi_mosi   <= 1'b0;
               busy       <= 1'b0;
               if (is_rd) data_out <= rx;
            end
            default: ;
         endcase
      end
endmodule

// File: tb/tb_spi_sram_word_if.sv
// tb_spi_sram_word_if: table-driven and random bench with a serial SRAM device model and a word-level reference memory.
module tb_spi_sram_word_if;
   logic        clk = 1'b0, rst = 1'b1;
   logic [15:0] addr_in = '0, data_in = '0;
   logic        start_read = 1'b0, start_write = 1'b0, start_write3 = 1'b0;
   logic [15:0] data_out, data_out3;
   logic        busy, spi_select, spi_clk_out, spi_mosi, spi_miso = 1'b0;
   logic        busy3, sel3, sck3, mosi3, miso3 = 1'b0;

   int n_chk = 0, n_err = 0;

   spi_sram_word_if dut (
      .clk(clk), .rst(rst), .addr_in(addr_in), .data_in(data_in),
      .start_read(start_read), .start_write(start_write), .data_out(data_out),
      .busy(busy), .spi_select(spi_select), .spi_clk_out(spi_clk_out),
      .spi_mosi(spi_mosi), .spi_miso(spi_miso));

   spi_sram_word_if #(.CLK_DIV(3)) dut3 (
      .clk(clk), .rst(rst), .addr_in(addr_in), .data_in(data_in),
      .start_read(1'b0), .start_write(start_write3), .data_out(data_out3),
      .busy(busy3), .spi_select(sel3), .spi_clk_out(sck3),
      .spi_mosi(mosi3), .spi_miso(miso3));

   always #5 clk = ~clk;

   function automatic logic [7:0] pat(input logic [15:0] a);
      return a[7:0] ^ 8'hA5;
   endfunction

   // serial SRAM device: decodes frames from the pins, sequential mode with 16-bit wrap
   typedef struct { int n; logic [63:0] bits; } frm_t;
   frm_t        frames[$];
   logic [7:0]  dev_mem [int];
   logic [63:0] dsh = '0;
   int          dnb = 0;
   logic [7:0]  dcmd = '0;
   logic [15:0] drd = '0;

   function automatic logic [7:0] dev_rd(input logic [15:0] a);
      return dev_mem.exists(int'(a)) ? dev_mem[int'(a)] : pat(a);
   endfunction

   always @(posedge spi_clk_out or posedge spi_select) begin
      if (spi_select) begin
         frames.push_back('{dnb, dsh});
         if (dnb == 40 && dcmd == 8'h02) begin
            dev_mem[int'(dsh[31:16])] = dsh[15:8];
            dev_mem[int'(16'(dsh[31:16] + 16'd1))] = dsh[7:0];
         end
         dnb = 0; dsh = '0; dcmd = '0;
      end else begin
         dsh = {dsh[62:0], spi_mosi};
         dnb++;
         if (dnb == 8) dcmd = dsh[7:0];
         if (dnb == 24) drd = {dev_rd(dsh[15:0]), dev_rd(dsh[15:0] + 16'd1)};
      end
   end

   always @(negedge spi_clk_out)
      spi_miso <= (dcmd == 8'h03 && dnb >= 24 && dnb < 40) ? drd[39 - dnb] : 1'b0;

   logic [63:0] sh3 = '0;
   int          n3 = 0;
   always @(posedge sck3) begin
      sh3 <= {sh3[62:0], mosi3};
      n3  <= n3 + 1;
   end

   // word-level reference: big-endian word at a, a+1 (16-bit wrap)
   logic [7:0]  ref_mem [int];
   logic [15:0] exp_dout = '0;

   function automatic logic [7:0] ref_rb(input logic [15:0] a);
      return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : pat(a);
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic release_rst();
      int cnt;
      @(negedge clk) rst = 1'b0;
      frames.delete();
      exp_dout = '0;
`ifdef SPI_SRAM_INIT_EN
      @(posedge clk); #1;
      cnt = 0;
      while (busy && cnt < 500) begin cnt++; @(posedge clk); #1; end
      chk("init_busy_cycles", cnt, 33);
      if (frames.size() == 0) chk("init_frame_present", 0, 1);
      else begin
         frm_t f = frames.pop_front();
         chk("init_sck_edges", f.n, 16);
         chk("init_mosi", f.bits[15:0], 16'h0140);
      end
      cnt = 0;
      while (busy3 && cnt < 500) begin cnt++; @(posedge clk); #1; end
`else
      repeat (3) begin
         @(posedge clk); #1;
         chk("idle_busy", busy, 0);
         chk("idle_select", spi_select, 1);
      end
`endif
      chk("post_rst_dout", data_out, 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_select", spi_select, 1);
      chk("rst_sck", spi_clk_out, 0);
      chk("rst_mosi", spi_mosi, 0);
      chk("rst_busy", busy, 0);
      chk("rst_dout", data_out, 0);
      release_rst();
   endtask

   task automatic do_txn(input string nm, input bit wr, input bit rd, input logic [15:0] a,
                         input logic [15:0] d, input int inject_at, input bit use_tbl,
                         input logic [15:0] tbl_exp);
      int cnt;
      logic [39:0] ef;
      @(negedge clk);
      addr_in = a; data_in = d; start_write = wr; start_read = rd;
      @(posedge clk); #1;
      start_write = 1'b0; start_read = 1'b0;
      addr_in = 16'($urandom); data_in = 16'($urandom);
      chk({nm, "_busy_rise"}, busy, 1);
      chk({nm, "_select_low"}, spi_select, 0);
      cnt = 1;
      while (cnt < 2000) begin
         @(posedge clk); #1;
         if (!busy) break;
         cnt++;
         start_read = (cnt == inject_at);
      end
      start_read = 1'b0;
      chk({nm, "_busy_cycles"}, cnt, 81);
      chk({nm, "_select_high"}, spi_select, 1);
      if (wr) begin
         ref_mem[int'(a)] = d[15:8];
         ref_mem[int'(16'(a + 16'd1))] = d[7:0];
      end else exp_dout = {ref_rb(a), ref_rb(a + 16'd1)};
      chk({nm, "_dout"}, data_out, use_tbl ? tbl_exp : exp_dout);
      ef = wr ? {8'h02, a, d} : {8'h03, a, 16'h0000};
      if (frames.size() == 0) chk({nm, "_frame_present"}, 0, 1);
      else begin
         frm_t f = frames.pop_front();
         chk({nm, "_sck_edges"}, f.n, 40);
         chk({nm, "_mosi_frame"}, f.bits[39:0], ef);
      end
   endtask

   typedef struct { bit wr; logic [15:0] a, d, exp; } vec_t;
   vec_t tbl[8];

   initial begin
      int k;
      tbl[0] = '{1'b1, 16'h1234, 16'hBEEF, 16'h0000};
      tbl[1] = '{1'b0, 16'h1234, 16'h0000, 16'hBEEF};
      tbl[2] = '{1'b1, 16'h0002, 16'h5A5A, 16'hBEEF};
      tbl[3] = '{1'b1, 16'hFFFF, 16'h1357, 16'hBEEF};
      tbl[4] = '{1'b0, 16'hFFFF, 16'h0000, 16'h1357};
      tbl[5] = '{1'b0, 16'h0000, 16'h0000, 16'h57A4};
      tbl[6] = '{1'b0, 16'h0100, 16'h0000, 16'hA5A4};
      tbl[7] = '{1'b0, 16'h0002, 16'h0000, 16'h5A5A};

      do_reset();
      foreach (tbl[i]) do_txn($sformatf("tbl%0d", i), tbl[i].wr, !tbl[i].wr, tbl[i].a, tbl[i].d, -1, 1'b1, tbl[i].exp);

      // both starts: write wins; a read pulse mid-transaction is ignored
      do_txn("prio", 1'b1, 1'b1, 16'h0040, 16'h00FF, 30, 1'b1, 16'h5A5A);
      repeat (5) @(posedge clk);
      #1;
      chk("prio_no_extra_busy", busy, 0);
      chk("prio_no_extra_frame", frames.size(), 0);
      do_txn("prio_rd", 1'b0, 1'b1, 16'h0040, 16'h0000, -1, 1'b1, 16'h00FF);

      // reset during a read aborts it and clears data_out
      @(negedge clk);
      addr_in = 16'h1234; start_read = 1'b1;
      @(posedge clk); #1;
      start_read = 1'b0;
      k = 0;
      while (dnb < 20 && k < 500) begin @(posedge clk); #1; k++; end
      chk("abort_reached_bit20", dnb, 20);
      rst = 1'b1;
      #1;
      chk("abort_select", spi_select, 1);
      chk("abort_busy", busy, 0);
      chk("abort_sck", spi_clk_out, 0);
      chk("abort_dout", data_out, 0);
      repeat (2) @(posedge clk);
      release_rst();
      do_txn("after_abort", 1'b0, 1'b1, 16'h0002, 16'h0000, -1, 1'b1, 16'h5A5A);

      // CLK_DIV=3 instance
      k = 0;
      while (busy3 && k < 500) begin @(posedge clk); #1; k++; end
      begin
         int base, cnt;
         base = n3;
         @(negedge clk);
         addr_in = 16'h0777; data_in = 16'hC3A5; start_write3 = 1'b1;
         @(posedge clk); #1;
         start_write3 = 1'b0;
         cnt = 0;
         while (busy3 && cnt < 2000) begin cnt++; @(posedge clk); #1; end
         chk("div3_busy_cycles", cnt, 241);
         chk("div3_sck_edges", n3 - base, 40);
         chk("div3_mosi_frame", sh3[39:0], {8'h02, 16'h0777, 16'hC3A5});
         chk("div3_dout", data_out3, 0);
      end

      for (int i = 0; i < 40; i++) begin
         logic [15:0] a;
         bit w;
         w = 1'($urandom_range(0, 1));
         a = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom_range(0, 15));
         do_txn($sformatf("rnd%0d", i), w, !w, a, 16'($urandom), -1, 1'b0, 16'h0000);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
